alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-side initiator for the 8-bit combinational ALU (ops: add, sub, and, or, xor, shl, shr, slt).
//  Accepts register-style commands over valid/ready and holds a small register file.
//  Issues registered operands/opcode to the ALU, captures result/zero/overflow one cycle later,
//  writes back to the register file and returns a response over valid/ready.
// PARAMETERS
//  DW    8   datapath width; must match ALU operand width
//  NREG  4   register-file entries
//  AW    2   register index width, clog2(NREG)
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  rst_n         in   1   synchronous active-low reset
//  cmd_valid     in   1   command present
//  cmd_ready     out  1   sequencer can accept (IDLE only)
//  cmd_li        in   1   1 = load-immediate, 0 = ALU op
//  cmd_op        in   3   ALU opcode (000 add .. 111 slt), ignored when cmd_li=1
//  cmd_rd        in   AW  destination register
//  cmd_rs1       in   AW  operand A register
//  cmd_rs2       in   AW  operand B register
//  cmd_imm       in   DW  immediate for load-immediate
//  alu_a         out  DW  registered operand A to ALU
//  alu_b         out  DW  registered operand B to ALU
//  alu_op        out  3   registered opcode to ALU
//  alu_result    in   DW  ALU result (combinational from alu_a/alu_b/alu_op)
//  alu_zero      in   1   ALU zero flag
//  alu_overflow  in   1   ALU overflow flag
//  rsp_valid     out  1   response present
//  rsp_ready     in   1   consumer takes response
//  rsp_data      out  DW  value written to cmd_rd
//  rsp_zero      out  1   zero flag of that value
//  rsp_ovf       out  1   overflow flag of that operation
//  sticky_ovf    out  1   set by any captured overflow, cleared by clr_ovf
//  clr_ovf       in   1   clear sticky_ovf
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; all regs, alu_a/b/op, rsp_* , sticky_ovf = 0; cmd_ready=1 next cycle.
//  FSM: IDLE -> EXEC -> RESP -> IDLE (ALU op); IDLE -> RESP -> IDLE (load-immediate).
//  IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready at edge T:
//   ALU op: alu_a<=rf[rs1], alu_b<=rf[rs2], alu_op<=cmd_op, latch rd; -> EXEC.
//   LI: rf[rd]<=cmd_imm, rsp_data<=imm, rsp_zero<=(imm==0), rsp_ovf<=0; -> RESP.
//  EXEC (one cycle, T+1): ALU settles; at edge rf[rd]<=alu_result, rsp_data<=alu_result,
//   rsp_zero<=alu_zero, rsp_ovf<=alu_overflow; sticky_ovf<=1 if alu_overflow; -> RESP.
//   Flags captured exactly as presented by the ALU, never recomputed.
//  RESP: rsp_valid=1; rsp_* stable until rsp_valid&rsp_ready; then -> IDLE, rsp_valid=0.
//  Latency: ALU op rsp_valid at T+2; LI rsp_valid at T+1. Throughput: one cmd per 3 (ALU) / 2 (LI) cycles min.
//  cmd_ready=0 in EXEC/RESP; cmd_valid there is ignored, no state change.
//  alu_a/b/op hold last issued values outside EXEC (no toggling).
//  rs1==rs2, rd==rs1/rs2 legal: operands sampled at accept, write-back at end of EXEC.
//  Shift amount is alu_b[2:0] inside ALU; sequencer passes full DW unmodified.
//  clr_ovf and overflow capture in same cycle: set wins (sticky_ovf=1).
//  clr_ovf honoured in any state.
//  rst_n low mid-EXEC/RESP: pending command dropped, no write-back, rsp_valid=0 next cycle.
// TESTING
//  Reset; LI r0=0x7F, LI r1=0x01, ADD r2=r0+r1 -> rsp_data=0x80, rsp_ovf=1, rsp_zero=0, sticky_ovf=1.
//  SUB r3=r1-r1 -> rsp_data=0x00, rsp_zero=1, rsp_ovf=0; rsp_valid exactly 2 cycles after accept.
//  LI r2=0x80; SLT r3=r2,r0 -> rsp_data=0x01; SLT r3=r0,r2 -> 0x00, rsp_zero=1.
//  Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0, no new cmd accepted.
//  Assert clr_ovf in the EXEC cycle of an overflowing ADD -> sticky_ovf=1 after edge; clr alone -> 0.
//  Pull rst_n low during EXEC of ADD r2 -> r2 reads 0 afterward, rsp_valid=0, cmd_ready=1 next cycle.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Command-side initiator for an external 8-bit combinational ALU.
//            Accepts register-style commands (load-immediate or ALU op) over
//            valid/ready and keeps a small register file. For an ALU op it
//            presents registered operands/opcode for one EXEC cycle, captures
//            result and flags at the end of that cycle, writes the result back
//            and returns a response over valid/ready.
// Ports    : clk, rst_n (sync, active low)
//            cmd_valid/cmd_ready, cmd_li, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
//            cmd_imm                      - command channel
//            alu_a, alu_b, alu_op         - registered ALU inputs
//            alu_result, alu_zero,
//            alu_overflow                 - ALU outputs
//            rsp_valid/rsp_ready, rsp_data, rsp_zero, rsp_ovf - response channel
//            sticky_ovf, clr_ovf          - accumulated overflow flag and clear
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_li,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [DW-1:0] cmd_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    input  logic          alu_overflow,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero,
    output logic          rsp_ovf,
    output logic          sticky_ovf,
    input  logic          clr_ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_accept;

    logic [DW-1:0] r_rf [NREG];
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [2:0]    r_alu_op;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_zero;
    logic          r_rsp_ovf;
    logic          r_sticky_ovf;

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign w_accept  = cmd_valid && (r_state == S_IDLE);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    // Load-immediate needs no ALU pass, so it skips EXEC.
                    w_state_nxt = cmd_li ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: register file, ALU operand registers, response registers.
    // Operands are sampled at accept, so rd aliasing rs1/rs2 is harmless: the
    // write-back lands only at the end of EXEC.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_rd       <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (cmd_li) begin
                    r_rf[cmd_rd] <= cmd_imm;
                    r_rsp_data   <= cmd_imm;
                    r_rsp_zero   <= (cmd_imm == '0);
                    r_rsp_ovf    <= 1'b0;
                end else begin
                    // ALU inputs only move here, so they stay quiet elsewhere.
                    r_alu_a  <= r_rf[cmd_rs1];
                    r_alu_b  <= r_rf[cmd_rs2];
                    r_alu_op <= cmd_op;
                    r_rd     <= cmd_rd;
                end
            end
            if (r_state == S_EXEC) begin
                // Flags are taken verbatim from the ALU.
                r_rf[r_rd] <= alu_result;
                r_rsp_data <= alu_result;
                r_rsp_zero <= alu_zero;
                r_rsp_ovf  <= alu_overflow;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky overflow: a capture in the same cycle as a clear wins.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky_ovf <= 1'b0;
        end else if ((r_state == S_EXEC) && alu_overflow) begin
            r_sticky_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_sticky_ovf <= 1'b0;
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_data   = r_rsp_data;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_ovf    = r_rsp_ovf;
    assign sticky_ovf = r_sticky_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Directed self-checking bench for alu_cmd_sequencer. Provides a
//            behavioural 8-bit ALU on the alu_* ports and drives command
//            sequences with hand-computed expected responses.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int DW = 8;
    localparam int AW = 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_li;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [DW-1:0] cmd_imm;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          alu_overflow;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;
    logic          rsp_ovf;
    logic          sticky_ovf;
    logic          clr_ovf;

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] g_data;
    logic          g_zero;
    logic          g_ovf;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DW(DW), .NREG(4), .AW(AW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_li       (cmd_li),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_imm      (cmd_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_zero     (rsp_zero),
        .rsp_ovf      (rsp_ovf),
        .sticky_ovf   (sticky_ovf),
        .clr_ovf      (clr_ovf)
    );

    // Behavioural ALU: signed overflow for add/sub, shift amount alu_b[2:0].
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            3'd1: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = alu_a << alu_b[2:0];
            3'd6: alu_result = alu_a >> alu_b[2:0];
            default: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 8'd1 : 8'd0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return just after the edge that accepts it.
    task automatic issue(input logic li, input logic [2:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [DW-1:0] imm);
        int n;
        cmd_li    = li;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_total++;
            n_bad++;
            $display("FAIL issue_timeout: cmd_ready stuck low");
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for a response, capture it, and complete the handshake.
    task automatic get_rsp(input string tag);
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_total++;
            n_bad++;
            $display("FAIL %s_rsp_timeout: rsp_valid stuck low", tag);
        end
        g_data = rsp_data;
        g_zero = rsp_zero;
        g_ovf  = rsp_ovf;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_li    = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        cmd_imm   = '0;
        rsp_ready = 1'b0;
        clr_ovf   = 1'b0;

        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'h0);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        // LI r0=0x7F: response visible right after accept
        issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h7F);
        check("li_latency", 32'(rsp_valid), 32'd1);
        get_rsp("li_r0");
        check("li_r0_data", 32'(g_data), 32'h7F);
        check("li_r0_zero", 32'(g_zero), 32'd0);
        check("idle_ready", 32'(cmd_ready), 32'd1);

        issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h01);
        get_rsp("li_r1");
        check("li_r1_data", 32'(g_data), 32'h01);

        // ADD r2=r0+r1: 0x7F+0x01 overflows signed
        issue(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00);
        check("add_exec_noresp", 32'(rsp_valid), 32'd0);
        check("add_alu_a", 32'(alu_a), 32'h7F);
        check("add_alu_b", 32'(alu_b), 32'h01);
        check("add_alu_op", 32'(alu_op), 32'(OP_ADD));
        get_rsp("add");
        check("add_data", 32'(g_data), 32'h80);
        check("add_ovf", 32'(g_ovf), 32'd1);
        check("add_zero", 32'(g_zero), 32'd0);
        check("add_sticky", 32'(sticky_ovf), 32'd1);

        // SUB r3=r1-r1 with exact two-cycle latency
        issue(1'b0, OP_SUB, 2'd3, 2'd1, 2'd1, 8'h00);
        check("sub_t1_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("sub_t2_valid", 32'(rsp_valid), 32'd1);
        get_rsp("sub");
        check("sub_data", 32'(g_data), 32'h00);
        check("sub_zero", 32'(g_zero), 32'd1);
        check("sub_ovf", 32'(g_ovf), 32'd0);

        // Signed compare: -128 < 127
        issue(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h80);
        get_rsp("li_r2");
        issue(1'b0, OP_SLT, 2'd3, 2'd2, 2'd0, 8'h00);
        get_rsp("slt_a");
        check("slt_neg_lt_pos", 32'(g_data), 32'h01);
        issue(1'b0, OP_SLT, 2'd3, 2'd0, 2'd2, 8'h00);
        get_rsp("slt_b");
        check("slt_pos_lt_neg", 32'(g_data), 32'h00);
        check("slt_zero", 32'(g_zero), 32'd1);

        // Back-pressure: XOR r3=r0^r1=0x7E held while a competing LI waits
        issue(1'b0, OP_XOR, 2'd3, 2'd0, 2'd1, 8'h00);
        tick();
        cmd_li    = 1'b1;
        cmd_rd    = 2'd0;
        cmd_imm   = 8'h55;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'(rsp_data), 32'h7E);
            check("stall_ready", 32'(cmd_ready), 32'd0);
            check("stall_alu_a", 32'(alu_a), 32'h7F);
            tick();
        end
        cmd_valid = 1'b0;
        get_rsp("xor");
        check("xor_data", 32'(g_data), 32'h7E);
        issue(1'b0, OP_OR, 2'd3, 2'd0, 2'd0, 8'h00);
        get_rsp("r0_intact");
        check("stall_no_accept", 32'(g_data), 32'h7F);

        // Sticky overflow: clear, then set wins over a simultaneous clear
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_sticky", 32'(sticky_ovf), 32'd0);
        issue(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("set_wins", 32'(sticky_ovf), 32'd1);
        get_rsp("add2");
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_alone", 32'(sticky_ovf), 32'd0);

        // Reset during EXEC of ADD r2: no write-back, no response
        issue(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h33);
        get_rsp("li_r2b");
        issue(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstx_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("rstx_rsp_valid2", 32'(rsp_valid), 32'd0);
        issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h05);
        get_rsp("li_r0b");
        issue(1'b0, OP_OR, 2'd3, 2'd2, 2'd0, 8'h00);
        get_rsp("r2_read");
        check("rstx_r2_cleared", 32'(g_data), 32'h05);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
